// File: rtl/adbg_tap_ctrl.sv
// IEEE 1149.1 TAP controller feeding the debug top: TAP state machine, instruction
// register, IDCODE/BYPASS data registers and the TDO return mux.
module adbg_tap_ctrl #(
    parameter int                  IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VALUE = 32'h249511C3,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE    = 4'b0010,
    parameter logic [IR_WIDTH-1:0] IR_DEBUG     = 4'b1000,
    parameter logic [IR_WIDTH-1:0] IR_BYPASS    = 4'b1111
) (
    input  logic tck_i,
    input  logic trstn_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    input  logic debug_tdo_i,
    output logic shift_dr_o,
    output logic pause_dr_o,
    output logic update_dr_o,
    output logic capture_dr_o,
    output logic debug_select_o,
    output logic test_logic_reset_o,
    output logic run_test_idle_o
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    // Fixed 01 in the two LSBs lets a chain walker locate IR boundaries.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t          state_reg, state_next;
    logic [IR_WIDTH-1:0] ir_reg;
    logic [IR_WIDTH-1:0] ir_shift_reg;
    logic [31:0]         idcode_shift_reg;
    logic                bypass_reg;
    logic                sel_idcode;
    logic                sel_debug;

    always_ff @(posedge tck_i) begin
        if (!trstn_i) state_reg <= TLR;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TLR:    state_next = tms_i ? TLR    : RTI;
            RTI:    state_next = tms_i ? SEL_DR : RTI;
            SEL_DR: state_next = tms_i ? SEL_IR : CAP_DR;
            CAP_DR: state_next = tms_i ? EX1_DR : SH_DR;
            SH_DR:  state_next = tms_i ? EX1_DR : SH_DR;
            EX1_DR: state_next = tms_i ? UPD_DR : PAU_DR;
            PAU_DR: state_next = tms_i ? EX2_DR : PAU_DR;
            EX2_DR: state_next = tms_i ? UPD_DR : SH_DR;
            UPD_DR: state_next = tms_i ? SEL_DR : RTI;
            SEL_IR: state_next = tms_i ? TLR    : CAP_IR;
            CAP_IR: state_next = tms_i ? EX1_IR : SH_IR;
            SH_IR:  state_next = tms_i ? EX1_IR : SH_IR;
            EX1_IR: state_next = tms_i ? UPD_IR : PAU_IR;
            PAU_IR: state_next = tms_i ? EX2_IR : PAU_IR;
            EX2_IR: state_next = tms_i ? UPD_IR : SH_IR;
            UPD_IR: state_next = tms_i ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // ir_reg only moves on Update-IR or on the way into Test-Logic-Reset.
    always_ff @(posedge tck_i) begin
        if (!trstn_i) begin
            ir_reg       <= IR_IDCODE;
            ir_shift_reg <= '0;
        end else begin
            if (state_reg == CAP_IR)
                ir_shift_reg <= IR_CAPTURE;
            else if (state_reg == SH_IR)
                ir_shift_reg <= {tdi_i, ir_shift_reg[IR_WIDTH-1:1]};

            if (state_next == TLR)
                ir_reg <= IR_IDCODE;
            else if (state_reg == UPD_IR)
                ir_reg <= ir_shift_reg;
        end
    end

    assign sel_idcode = (ir_reg == IR_IDCODE);
    assign sel_debug  = (ir_reg == IR_DEBUG);

    always_ff @(posedge tck_i) begin
        if (!trstn_i) begin
            idcode_shift_reg <= '0;
            bypass_reg       <= 1'b0;
        end else if (sel_idcode) begin
            if (state_reg == CAP_DR)
                idcode_shift_reg <= IDCODE_VALUE;
            else if (state_reg == SH_DR)
                idcode_shift_reg <= {tdi_i, idcode_shift_reg[31:1]};
        end else if (!sel_debug) begin
            if (state_reg == CAP_DR)
                bypass_reg <= 1'b0;
            else if (state_reg == SH_DR)
                bypass_reg <= tdi_i;
        end
    end

    always_comb begin
        tdo_o = 1'b0;
        if (state_reg == SH_IR)
            tdo_o = ir_shift_reg[0];
        else if (state_reg == SH_DR) begin
            if (sel_idcode)     tdo_o = idcode_shift_reg[0];
            else if (sel_debug) tdo_o = debug_tdo_i;
            else                tdo_o = bypass_reg;
        end
    end

    assign tdo_oe_o           = (state_reg == SH_IR) || (state_reg == SH_DR);
    assign shift_dr_o         = (state_reg == SH_DR);
    assign pause_dr_o         = (state_reg == PAU_DR);
    assign update_dr_o        = (state_reg == UPD_DR);
    assign capture_dr_o       = (state_reg == CAP_DR);
    assign test_logic_reset_o = (state_reg == TLR);
    assign run_test_idle_o    = (state_reg == RTI);
    assign debug_select_o     = sel_debug;

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Bench for adbg_tap_ctrl: directed vector table, hand-written scan sequences and
// random TMS/TDI traffic checked against a table-driven TAP reference model.
module tb_adbg_tap_ctrl;

    logic tck_i = 1'b0;
    logic trstn_i, tms_i, tdi_i, debug_tdo_i;
    logic tdo_o, tdo_oe_o, shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o;
    logic debug_select_o, test_logic_reset_o, run_test_idle_o;

    int checks = 0;
    int failures = 0;

    adbg_tap_ctrl dut (
        .tck_i(tck_i), .trstn_i(trstn_i), .tms_i(tms_i), .tdi_i(tdi_i),
        .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o), .debug_tdo_i(debug_tdo_i),
        .shift_dr_o(shift_dr_o), .pause_dr_o(pause_dr_o), .update_dr_o(update_dr_o),
        .capture_dr_o(capture_dr_o), .debug_select_o(debug_select_o),
        .test_logic_reset_o(test_logic_reset_o), .run_test_idle_o(run_test_idle_o)
    );

    always #5 tck_i = ~tck_i;

    // Reference model. States numbered in the order the TAP diagram lists them:
    // 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR
    // 9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int          m_st;
    logic [3:0]  m_ir, m_irsh;
    logic [31:0] m_id;
    logic        m_byp;
    bit          model_valid = 0;

    // Observed/expected output bundle:
    // {tlr, rti, capture, shift, pause, update, debug_select, tdo_oe, tdo}
    logic [8:0] obs;

    function automatic logic [8:0] model_out(input logic dtdo);
        logic t;
        t = 1'b0;
        if (m_st == 11) t = m_irsh[0];
        else if (m_st == 4) t = (m_ir == 4'h2) ? m_id[0] : (m_ir == 4'h8) ? dtdo : m_byp;
        return {m_st == 0, m_st == 1, m_st == 3, m_st == 4, m_st == 6, m_st == 8,
                m_ir == 4'h8, (m_st == 4) || (m_st == 11), t};
    endfunction

    task automatic model_reset();
        m_st = 0; m_ir = 4'h2; m_irsh = 4'h0; m_id = 32'h0; m_byp = 1'b0;
    endtask

    task automatic model_step(input logic tms, input logic tdi, input logic trstn);
        int nst;
        if (!trstn) begin
            model_reset();
            return;
        end
        nst = tms ? nxt1[m_st] : nxt0[m_st];
        case (m_st)
            10: m_irsh = 4'b0001;
            11: m_irsh = (m_irsh >> 1) | ({3'b000, tdi} << 3);
            15: m_ir = m_irsh;
            3:  if (m_ir == 4'h2) m_id = 32'h249511C3;
                else if (m_ir != 4'h8) m_byp = 1'b0;
            4:  if (m_ir == 4'h2) m_id = (m_id >> 1) | ({31'h0, tdi} << 31);
                else if (m_ir != 4'h8) m_byp = tdi;
            default: ;
        endcase
        if (nst == 0) m_ir = 4'h2;
        m_st = nst;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One TCK cycle: drive inputs, sample outputs on the falling edge, advance the model.
    task automatic drive(input logic tms, input logic tdi, input logic trstn, input logic dtdo);
        logic [8:0] e;
        tms_i = tms; tdi_i = tdi; trstn_i = trstn; debug_tdo_i = dtdo;
        e = model_out(dtdo);
        @(negedge tck_i);
        obs = {test_logic_reset_o, run_test_idle_o, capture_dr_o, shift_dr_o, pause_dr_o,
               update_dr_o, debug_select_o, tdo_oe_o, tdo_o};
        if (model_valid) check("model", {23'h0, obs}, {23'h0, e});
        @(posedge tck_i);
        model_step(tms, tdi, trstn);
        #1;
    endtask

    task automatic goto_rti();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // From RTI: scan an IR value, return the captured bits, end back in RTI.
    task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, val[i], 1'b1, 1'b0);
            cap[i] = obs[0];
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // From RTI: 4-bit DR scan in bypass, return tdo bits, end back in RTI.
    task automatic bypass_scan(input logic [3:0] din, output logic [3:0] dout);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, din[i], 1'b1, 1'b1);
            dout[i] = obs[0];
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic       tms, tdi, trstn, dtdo;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs [27];

    initial begin
        logic [3:0]  cap, dout;
        logic [31:0] word;
        int          oe_cnt;

        // Expected bundle is what the outputs show during the cycle the row is applied.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 9'b100000000}; // TLR under reset
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b100000000};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b100000000};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b100000000};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b100000000};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b100000000};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b100000000};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b010000000}; // RTI
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000000000}; // SelDR
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000000}; // SelIR
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000000}; // CapIR
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000011}; // ShIR, captured 1
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000010};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000010};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 9'b000000010};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000000000}; // Ex1IR
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000000}; // UpdIR
        vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b010000100}; // RTI, debug selected
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000000100}; // SelDR
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b001000100}; // CapDR
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b000100111}; // ShDR, tdo follows debug
        vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000100110};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'b000000100}; // Ex1DR
        vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000010100}; // PauDR
        vecs[24] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'b000000100}; // Ex2DR
        vecs[25] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b000001100}; // UpdDR
        vecs[26] = '{1'b0, 1'b0, 1'b1, 1'b0, 9'b010000100}; // RTI

        tms_i = 1'b1; tdi_i = 1'b0; trstn_i = 1'b0; debug_tdo_i = 1'b0;
        @(posedge tck_i);
        @(posedge tck_i);
        model_reset();
        model_valid = 1;
        #1;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].tms, vecs[i].tdi, vecs[i].trstn, vecs[i].dtdo);
            check($sformatf("vec%0d", i), {23'h0, obs}, {23'h0, vecs[i].exp});
        end

        // IDCODE after TLR: 32 bits LSB first, OE only while shifting.
        goto_rti();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        word = 32'h0;
        oe_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            drive(i == 31, 1'($urandom), 1'b1, 1'b0);
            word[i] = obs[0];
            oe_cnt += int'(obs[1]);
        end
        check("idcode_word", word, 32'h249511C3);
        check("idcode_oe_cnt", oe_cnt, 32);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("ex1dr_oe", {31'h0, obs[1]}, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        load_ir(4'b1000, cap);
        check("ir_capture", {28'h0, cap}, 32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("debug_select", {31'h0, obs[2]}, 32'h1);

        load_ir(4'b1111, cap);
        bypass_scan(4'b1101, dout);
        check("bypass_1111", {28'h0, dout}, 32'hA);
        load_ir(4'b0110, cap);
        bypass_scan(4'b1101, dout);
        check("bypass_0110", {28'h0, dout}, 32'hA);

        // Reset two bits into an IR scan that would otherwise select BYPASS.
        load_ir(4'b1000, cap);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_mid_shir", {23'h0, obs}, {23'h0, 9'b100000000});

        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 99) < 40, 1'($urandom), $urandom_range(0, 99) != 0,
                  1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
